matrix_frame_loader: RTL and testbench

- Upstream stage of matrix_mult: receives the UART RX byte stream and assembles a frame: header, 4x4 matrix A, 4x4 matrix B.
- Drives matrix_a/matrix_b directly into matrix_mult.
- Gates matrix_mult through its active-low reset: holds mult_rst_n low while loading, releases it once a full frame is in, and holds it high until the downstream TX stage acknowledges the result.

---
 rtl/matrix_uart_pkg.sv | 20 ++
 rtl/byte_timeout.sv | 30 +++
 rtl/matrix_frame_loader.sv | 160 ++++++++++++++++
 tb/tb_matrix_frame_loader.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_uart_pkg.sv
// Shared constants, element/matrix types and loader state encoding for the
// UART-fed matrix multiplier path.
package matrix_uart_pkg;

    localparam int DIM    = 4;
    localparam int DATA_W = 8;

    typedef logic [DATA_W-1:0] byte_t;
    typedef byte_t [0:DIM-1][0:DIM-1] matrix_t;

    localparam byte_t HEADER = 8'hA5;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CHECK,
        RUN
    } state_t;

endpackage

// File: rtl/byte_timeout.sv
// Inter-byte idle timer: counts enabled cycles since the last clear and pulses
// expired on the cycle the count would reach TIMEOUT_CYCLES.
module byte_timeout #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count;

    // A clear in the expiry cycle wins, so a late byte still lands.
    assign expired = en && !clr && (count == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clr || expired) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/matrix_frame_loader.sv
// Assembles header + A + B frames from the UART RX stream and gates matrix_mult
// via mult_rst_n. Define MATRIX_FRAME_LOADER_CHECKSUM_EN to require a trailing XOR byte.
//
// state | meaning
// IDLE  | hunting for the header byte, matrix_mult held in reset
// LOAD  | collecting the 32 payload bytes row-major, A then B
// CHECK | waiting for the XOR checksum byte (checksum build only)
// RUN   | matrix_mult released, RX refused until result_ack
module matrix_frame_loader
    import matrix_uart_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output matrix_t           matrix_a,
    output matrix_t           matrix_b,
    output logic              mult_rst_n,
    input  logic              result_ack,
    output logic              busy,
    output logic              frame_err,
    output logic              overrun
);

    localparam int NELEM = DIM * DIM;
    localparam int IDX_W = $clog2(2 * NELEM);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * NELEM - 1);

    state_t           state;
    state_t           state_next;
    logic             err_next;
    logic             accept;
    logic             loading;
    logic             timed;
    logic             expired;
    logic [IDX_W-1:0] idx;
    matrix_t          a_q;
    matrix_t          b_q;
`ifdef MATRIX_FRAME_LOADER_CHECKSUM_EN
    byte_t            xor_q;
`endif

    assign rx_ready   = (state != RUN);
    assign accept     = rx_valid && rx_ready;
    assign busy       = (state != IDLE);
    assign mult_rst_n = (state == RUN);
    assign loading    = (state == LOAD) && accept;
    assign timed      = (state == LOAD) || (state == CHECK);
    assign matrix_a   = a_q;
    assign matrix_b   = b_q;

    byte_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clr     (accept || !timed),
        .en      (timed),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                if (accept && rx_data == HEADER) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (accept && idx == LAST_IDX) begin
`ifdef MATRIX_FRAME_LOADER_CHECKSUM_EN
                    state_next = CHECK;
`else
                    state_next = RUN;
`endif
                end else if (expired) begin
                    state_next = IDLE;
                    err_next   = 1'b1;
                end
            end
`ifdef MATRIX_FRAME_LOADER_CHECKSUM_EN
            CHECK: begin
                if (accept) begin
                    if (rx_data == xor_q) begin
                        state_next = RUN;
                    end else begin
                        state_next = IDLE;
                        err_next   = 1'b1;
                    end
                end else if (expired) begin
                    state_next = IDLE;
                    err_next   = 1'b1;
                end
            end
`endif
            RUN: begin
                if (result_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Matrices are only written in LOAD, so they stay frozen through CHECK/RUN
    // and keep partial contents after a timeout.
    always_ff @(posedge clk) begin
        if (!reset) begin
            a_q       <= '0;
            b_q       <= '0;
            idx       <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= err_next;
            overrun   <= rx_valid && !rx_ready;
            if (state == IDLE && accept && rx_data == HEADER) begin
                idx <= '0;
            end else if (loading) begin
                idx <= idx + IDX_W'(1);
            end
            for (int r = 0; r < DIM; r++) begin
                for (int c = 0; c < DIM; c++) begin
                    if (loading && idx == IDX_W'(r * DIM + c)) begin
                        a_q[r][c] <= rx_data;
                    end
                    if (loading && idx == IDX_W'(NELEM + r * DIM + c)) begin
                        b_q[r][c] <= rx_data;
                    end
                end
            end
        end
    end

`ifdef MATRIX_FRAME_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            xor_q <= '0;
        end else if (state == IDLE && accept && rx_data == HEADER) begin
            xor_q <= '0;
        end else if (loading) begin
            xor_q <= xor_q ^ rx_data;
        end
    end
`endif

endmodule

// File: tb/tb_matrix_frame_loader.sv
// Scoreboard bench for matrix_frame_loader: stimulus pushes expected events,
// a negedge monitor pops them when the DUT raises mult_rst_n, frame_err or overrun.
module tb_matrix_frame_loader;

    localparam int TMO = 16;
    localparam logic [1:0] EV_RUN = 2'd0;
    localparam logic [1:0] EV_ERR = 2'd1;
    localparam logic [1:0] EV_OVR = 2'd2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic rx_valid = 1'b0;
    logic result_ack = 1'b0;
    logic rx_ready, mult_rst_n, busy, frame_err, overrun;
    logic [0:3][0:3][7:0] matrix_a, matrix_b;

    int n_tests = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [1:0]        kind;
        logic [15:0][7:0]  a;
        logic [15:0][7:0]  b;
    } ev_t;

    ev_t evq[$];
    logic [15:0][7:0] ma, mb;
    logic [7:0] pay [32];

    matrix_frame_loader #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .matrix_a   (matrix_a),
        .matrix_b   (matrix_b),
        .mult_rst_n (mult_rst_n),
        .result_ack (result_ack),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] flat(input logic [0:3][0:3][7:0] m);
        logic [127:0] f;
        f = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                f[(r*4+c)*8 +: 8] = m[r][c];
        return f;
    endfunction

    task automatic put(input int k, input logic [7:0] v);
        if (k < 16) ma[k] = v;
        else        mb[k-16] = v;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        idle(gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic do_ack();
        result_ack = 1'b1;
        @(posedge clk); #1;
        result_ack = 1'b0;
        check("ack_rst_n_low", mult_rst_n, 0);
        check("ack_rx_ready", rx_ready, 1);
        check("ack_busy", busy, 0);
    endtask

    task automatic rand_payload();
        for (int k = 0; k < 32; k++) pay[k] = 8'($urandom_range(0, 255));
    endtask

    task automatic run_frame(input int max_gap, input bit long_gap, input bit ack_mid, input bit corrupt);
        logic [7:0] x;
        int g;
        x = 8'h00;
        send_byte(8'hA5, $urandom_range(0, max_gap));
        check("header_busy", busy, 1);
        for (int k = 0; k < 32; k++) begin
            g = (long_gap && k == 7) ? TMO - 1 : $urandom_range(0, max_gap);
            put(k, pay[k]);
            x ^= pay[k];
            if (k == 31) begin
                idle(g);
                g = 0;
                check("pre_last_rst_n", mult_rst_n, 0);
`ifndef MATRIX_FRAME_LOADER_CHECKSUM_EN
                evq.push_back(ev_t'{EV_RUN, ma, mb});
`endif
            end
            if (ack_mid && k == 10) result_ack = 1'b1;
            send_byte(pay[k], g);
            result_ack = 1'b0;
        end
`ifdef MATRIX_FRAME_LOADER_CHECKSUM_EN
        check("check_busy", busy, 1);
        check("check_rst_n", mult_rst_n, 0);
        evq.push_back(ev_t'{(corrupt ? EV_ERR : EV_RUN), ma, mb});
        send_byte(corrupt ? (x ^ 8'h01) : x, $urandom_range(0, max_gap));
        if (corrupt) begin
            check("cs_bad_err", frame_err, 1);
            check("cs_bad_rst_n", mult_rst_n, 0);
            check("cs_bad_busy", busy, 0);
        end
`endif
        if (!corrupt) begin
            check("run_rst_n", mult_rst_n, 1);
            check("run_busy", busy, 1);
            check("run_rx_ready", rx_ready, 0);
        end
    endtask

    // Monitor: one expected event per DUT-presented output.
    logic prev_rst = 1'b0;
    logic [1:0] mon_kind;
    bit mon_fire;
    ev_t mon_e;
    always @(negedge clk) begin
        mon_fire = 1'b0;
        mon_kind = EV_RUN;
        if (mult_rst_n === 1'b1 && prev_rst !== 1'b1) begin
            mon_fire = 1'b1; mon_kind = EV_RUN;
        end else if (frame_err === 1'b1) begin
            mon_fire = 1'b1; mon_kind = EV_ERR;
        end else if (overrun === 1'b1) begin
            mon_fire = 1'b1; mon_kind = EV_OVR;
        end
        prev_rst = mult_rst_n;
        if (mon_fire) begin
            if (evq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_event: got kind %0d expected no event", mon_kind);
            end else begin
                mon_e = evq.pop_front();
                check("event_kind", mon_kind, mon_e.kind);
                check("event_matrix_a", flat(matrix_a), mon_e.a);
                check("event_matrix_b", flat(matrix_b), mon_e.b);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1);
    end

    initial begin
        ma = '0;
        mb = '0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rst_n", mult_rst_n, 0);
        check("reset_busy", busy, 0);
        check("reset_rx_ready", rx_ready, 1);
        check("reset_frame_err", frame_err, 0);
        check("reset_overrun", overrun, 0);
        check("reset_matrix_a", flat(matrix_a), ma);
        check("reset_matrix_b", flat(matrix_b), mb);
        reset = 1'b1;
        idle(1);

        // Identity A, identity B with B[0][1]=20
        for (int k = 0; k < 32; k++)
            pay[k] = ((k % 16) % 5 == 0) ? 8'd1 : 8'd0;
        pay[17] = 8'd20;
        run_frame(0, 0, 0, 0);

        // Overrun in RUN drops the byte, state and matrices unchanged
        evq.push_back(ev_t'{EV_OVR, ma, mb});
        rx_data  = 8'd7;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        check("overrun_pulse", overrun, 1);
        check("overrun_rst_n", mult_rst_n, 1);
        check("overrun_busy", busy, 1);
        idle(1);
        check("overrun_one_cycle", overrun, 0);
        do_ack();

        // result_ack outside RUN is ignored
        result_ack = 1'b1;
        idle(1);
        result_ack = 1'b0;
        check("idle_ack_busy", busy, 0);

        // Leading garbage is discarded; header value inside payload is data
        send_byte(8'h00, 0);
        send_byte(8'hFF, 1);
        check("preamble_discard", busy, 0);
        rand_payload();
        pay[3]  = 8'hA5;
        pay[20] = 8'hA5;
        run_frame(4, 0, 1, 0);
        do_ack();

        // Timeout after 10 payload bytes; matrices keep partial contents
        rand_payload();
        send_byte(8'hA5, 0);
        for (int k = 0; k < 10; k++) begin
            put(k, pay[k]);
            send_byte(pay[k], 0);
        end
        evq.push_back(ev_t'{EV_ERR, ma, mb});
        for (int i = 1; i < TMO; i++) begin
            idle(1);
            check("timeout_not_yet", frame_err, 0);
        end
        idle(1);
        check("timeout_err", frame_err, 1);
        check("timeout_busy", busy, 0);
        check("timeout_rst_n", mult_rst_n, 0);
        idle(1);
        check("timeout_err_one_cycle", frame_err, 0);

        // Reset in the middle of a frame
        rand_payload();
        send_byte(8'hA5, 0);
        for (int k = 0; k < 20; k++) send_byte(pay[k], 0);
        reset = 1'b0;
        idle(1);
        ma = '0;
        mb = '0;
        check("midreset_busy", busy, 0);
        check("midreset_rst_n", mult_rst_n, 0);
        check("midreset_matrix_a", flat(matrix_a), ma);
        check("midreset_matrix_b", flat(matrix_b), mb);
        reset = 1'b1;
        rand_payload();
        run_frame(3, 1, 0, 0);
        do_ack();

        // Random frames with random inter-byte gaps below the timeout
        for (int n = 0; n < 4; n++) begin
            rand_payload();
            idle($urandom_range(0, 5));
            run_frame(6, (n == 2), 0, 0);
            do_ack();
        end

`ifdef MATRIX_FRAME_LOADER_CHECKSUM_EN
        rand_payload();
        run_frame(2, 0, 0, 1);
        rand_payload();
        run_frame(1, 0, 0, 0);
        do_ack();
`endif

        idle(5);
        check("event_queue_drained", evq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
